// File: rtl/serial_seq_tx_if.sv
// serial_seq_tx_if
//   Bundles the request and serial-output signals of serial_seq_tx.
//   master : the party requesting transfers (bench, demo controller)
//   slave  : the transmitter itself
//
//   start     request a transfer (honoured only when the transmitter is idle)
//   seq_in    parallel pattern, captured on the accepting edge
//   len       number of bits to send; 0 or more than WIDTH means WIDTH
//   repeat_en replay the pattern until stop
//   stop      abort the transfer / leave repeat mode
//   x         serial data bit, MSB of the active window first
//   x_valid   x carries a pattern bit this cycle
//   busy      transfer in progress (sending or finishing)
//   done      one-cycle pulse after the last bit of a non-repeat transfer
//   wrap      last bit of a pass is on x
//   bit_idx   index into the pattern of the bit on x; 0 when not valid
interface serial_seq_tx_if #(
  parameter int WIDTH = 64,
  parameter int LEN_W = 7
);
  logic             start;
  logic [WIDTH-1:0] seq_in;
  logic [LEN_W-1:0] len;
  logic             repeat_en;
  logic             stop;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic             wrap;
  logic [LEN_W-1:0] bit_idx;

  modport master (
    output start, seq_in, len, repeat_en, stop,
    input  x, x_valid, busy, done, wrap, bit_idx
  );

  modport slave (
    input  start, seq_in, len, repeat_en, stop,
    output x, x_valid, busy, done, wrap, bit_idx
  );
endinterface

// File: rtl/serial_seq_tx.sv
// serial_seq_tx
//   Serial pattern transmitter feeding the sequence-detector FSMs. A
//   parallel pattern of up to WIDTH bits is captured with start and shifted
//   out MSB-first on x, one bit per clock, optionally replayed until stop.
//
//   Ports:
//     clk  single clock, all state changes on the rising edge
//     rst  synchronous, active-high reset
//     bus  serial_seq_tx_if.slave (request inputs, serial outputs)
//
//   x, x_valid, busy, done and bit_idx are registered so a downstream
//   detector sees a bit that is stable for the whole cycle. wrap is decoded
//   from registered state.
module serial_seq_tx #(
  parameter int WIDTH = 64,
  parameter int LEN_W = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_seq_tx_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
  localparam logic [LEN_W-1:0] ZERO_L  = '0;

  // Saturate the requested length into 1..WIDTH; zero also means "all".
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if ((l == ZERO_L) || (l > WIDTH_L)) begin
      return WIDTH_L;
    end
    return l;
  endfunction

  // Pick one bit out of the pattern; a shift keeps the index width free
  // of the pattern width.
  function automatic logic pick_bit(input logic [WIDTH-1:0] pat,
                                    input logic [LEN_W-1:0] idx);
    logic [WIDTH-1:0] sh;
    sh = pat >> idx;
    return sh[0];
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             rep_q, rep_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic             x_q, x_d;
  logic             xv_q;
  logic             busy_q;
  logic             done_q;

  // Next-state decode
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    rep_d   = rep_q;
    idx_d   = idx_q;

    unique case (state_q)
      IDLE: begin
        // start together with stop is treated as no request
        if (bus.start && !bus.stop) begin
          pat_d   = bus.seq_in;
          len_d   = clamp_len(bus.len);
          rep_d   = bus.repeat_en;
          idx_d   = clamp_len(bus.len) - ONE_L;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.stop) begin
          idx_d   = ZERO_L;
          state_d = IDLE;
        end else if (idx_q != ZERO_L) begin
          idx_d = idx_q - ONE_L;
        end else if (rep_q) begin
          // seamless reload: next pass starts on the very next cycle
          idx_d = len_q - ONE_L;
        end else begin
          idx_d   = ZERO_L;
          state_d = DONE;
        end
      end
      DONE: begin
        idx_d   = ZERO_L;
        state_d = IDLE;
      end
      default: begin
        idx_d   = ZERO_L;
        state_d = IDLE;
      end
    endcase

    // x is computed from next state so the output register holds the bit
    // that belongs to the cycle after the edge.
    x_d = (state_d == SEND) ? pick_bit(pat_d, idx_d) : 1'b0;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= ZERO_L;
      rep_q   <= 1'b0;
      idx_q   <= ZERO_L;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      xv_q    <= (state_d == SEND);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  // Pattern storage is pure data: its contents only matter while SEND.
  always_ff @(posedge clk) begin
    pat_q <= pat_d;
  end

  // Output mapping
  assign bus.x       = x_q;
  assign bus.x_valid = xv_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bit_idx = idx_q;
  assign bus.wrap    = xv_q && (idx_q == ZERO_L);

endmodule

// File: tb/tb_serial_seq_tx.sv
module tb_serial_seq_tx;
  localparam int WIDTH = 64;
  localparam int LEN_W = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_seq_tx_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  serial_seq_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic x;
    int   idx;
    logic wrap;
    int   cyc;
  } exp_t;

  exp_t bq[$];
  int   dq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   busy_lo = -1;
  int   busy_hi = -2;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int clamp_l(input int l);
    return (l == 0 || l > WIDTH) ? WIDTH : l;
  endfunction

  // Reference model: bit k of the stream is pattern[L-1 - (k mod L)],
  // appearing in cycle e+k; a completed transfer pulses done in cycle e+L.
  task automatic model(input logic [WIDTH-1:0] p, input int l, input int e,
                       input int total, input bit completes);
    int L;
    logic [WIDTH-1:0] sh;
    exp_t it;
    L = clamp_l(l);
    for (int k = 0; k < total; k++) begin
      it.idx  = L - 1 - (k % L);
      sh      = p >> it.idx;
      it.x    = sh[0];
      it.wrap = (it.idx == 0);
      it.cyc  = e + k;
      bq.push_back(it);
    end
    busy_lo = e;
    if (completes) begin
      dq.push_back(e + L);
      busy_hi = e + L;
    end else begin
      busy_hi = e + total - 1;
    end
  endtask

  task automatic accept(input logic [WIDTH-1:0] p, input int l, input bit r,
                        output int e);
    bus.seq_in    = p;
    bus.len       = l[LEN_W-1:0];
    bus.repeat_en = r;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e = cyc;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bq.size() == 0 && dq.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check("idle_timeout", 1, 0);
  endtask

  task automatic run_plain(input logic [WIDTH-1:0] p, input int l);
    int e;
    accept(p, l, 1'b0, e);
    model(p, l, e, clamp_l(l), 1'b1);
    wait_idle();
  endtask

  task automatic run_repeat(input logic [WIDTH-1:0] p, input int l, input int n);
    int e;
    accept(p, l, 1'b1, e);
    model(p, l, e, n, 1'b0);
    repeat (n - 1) @(posedge clk);
    #1;
    bus.stop = 1'b1;
    @(posedge clk);
    #1;
    bus.stop = 1'b0;
    check("stop_xvalid", bus.x_valid, 0);
    wait_idle();
  endtask

  // Monitor: pops expectations whenever the DUT presents a bit or a done.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.x_valid) begin
        if (bq.size() == 0) begin
          check("unexpected_bit", 1, 0);
        end else begin
          exp_t e;
          e = bq.pop_front();
          check("bit_cycle", cyc, e.cyc);
          check("bit_x", bus.x, e.x);
          check("bit_idx", bus.bit_idx, e.idx);
          check("bit_wrap", bus.wrap, e.wrap);
        end
      end else begin
        check("idle_outs", {bus.x, bus.wrap, bus.bit_idx}, 0);
        if (bq.size() != 0 && bq[0].cyc <= cyc) begin
          check("missing_bit", 0, 1);
          void'(bq.pop_front());
        end
      end
      if (bus.done) begin
        if (dq.size() == 0) check("unexpected_done", 1, 0);
        else check("done_cycle", cyc, dq.pop_front());
      end else if (dq.size() != 0 && dq[0] <= cyc) begin
        check("missing_done", 0, 1);
        void'(dq.pop_front());
      end
      check("busy", bus.busy, (cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    logic [WIDTH-1:0] p;
    int l;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.seq_in    = '0;
    bus.len       = '0;
    bus.repeat_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", bus.x, 0);
    check("rst_xvalid", bus.x_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_wrap", bus.wrap, 0);
    check("rst_idx", bus.bit_idx, 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // short pattern ...1011
    run_plain(64'hB, 4);
    // full-length clamp via 0 and via an oversize length
    run_plain(64'h00EB693952AE6A6C, 0);
    run_plain(64'h00EB693952AE6A6C, 100);
    // repeat 110, stop during the 7th bit
    run_repeat(64'h6, 3, 7);

    // start pulses during SEND and DONE are ignored
    p = 64'hA5C3_0F1E_7788_9911;
    accept(p, 8, 1'b0, e);
    model(p, 8, e, 8, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    bus.seq_in = ~p;
    bus.len    = 2;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    wait_idle();

    // start and stop together in IDLE: no transfer
    bus.seq_in = 64'hFF;
    bus.len    = 8;
    bus.start  = 1'b1;
    bus.stop   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("ss_xvalid", bus.x_valid, 0);
    check("ss_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    check("ss_xvalid2", bus.x_valid, 0);
    run_plain(64'h5A, 7);

    // reset mid-transfer at bit_idx 5
    p = 64'h96;
    accept(p, 8, 1'b0, e);
    model(p, 8, e, 3, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_idx", bus.bit_idx, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mrst_x", bus.x, 0);
    check("mrst_xvalid", bus.x_valid, 0);
    check("mrst_busy", bus.busy, 0);
    check("mrst_done", bus.done, 0);
    check("mrst_wrap", bus.wrap, 0);
    check("mrst_idx", bus.bit_idx, 0);
    wait_idle();
    run_plain(64'hC3, 8);

    // randomized transfers
    for (int t = 0; t < 24; t++) begin
      p = {$urandom, $urandom};
      l = $urandom_range(0, 127);
      if ($urandom_range(0, 3) == 0)
        run_repeat(p, l, $urandom_range(1, 2 * clamp_l(l) + 3));
      else
        run_plain(p, l);
    end

    repeat (3) @(posedge clk);
    #1;
    check("bits_left", bq.size(), 0);
    check("dones_left", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
